// File: rtl/cordic_polar_freq_est.sv
// cordic_polar_freq_est
// Sits after a CORDIC vector-to-polar core. Samples with too little amplitude
// are gated out. Consecutive phases of the remaining samples are differenced,
// with the difference wrapped back into (-pi, pi]. The result is instantaneous
// frequency in rad/sample, averaged over a window of 2^LOG2_N differences.
// Each window emits {peak amplitude, mean frequency} on a ready/valid stream.
module cordic_polar_freq_est #(
  parameter int unsigned LOG2_N     = 3,
  parameter logic [7:0]  AMP_THRESH = 8'd16,
  parameter logic [7:0]  PI_Q       = 8'd101,
  parameter logic [8:0]  TWO_PI_Q   = 9'd201
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_dout_tvalid,
  input  logic [15:0] s_axis_dout_tdata,
  input  logic        clr,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        locked,
  output logic        overrun
);

  localparam int unsigned ACC_W = 8 + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N;
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // SEEK: no reference phase is held. ACC: a reference is held and differences accumulate.
  typedef enum logic [0:0] {
    ST_SEEK = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Phase difference, wrapped back into [-(pi-1), pi-1] and truncated to 8 bits.
  // Ten bits of working width hold any difference of two signed bytes
  // plus or minus 2*pi without overflow.
  function automatic logic signed [7:0] wrap_diff(
    input logic signed [7:0] cur,
    input logic signed [7:0] prev
  );
    logic signed [9:0] d;
    logic signed [9:0] lim;
    logic signed [9:0] two_pi;
    d      = $signed({{2{cur[7]}}, cur}) - $signed({{2{prev[7]}}, prev});
    lim    = $signed({2'b00, PI_Q}) - 10'sd1;
    two_pi = $signed({1'b0, TWO_PI_Q});
    if (d > lim) begin
      d = d - two_pi;
    end else if (d < -lim) begin
      d = d + two_pi;
    end else begin
      d = d;
    end
    return d[7:0];
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [7:0]        r_prev_phase;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [7:0]               r_peak;
  logic                     r_tvalid;
  logic [15:0]              r_tdata;
  logic                     r_overrun;

  logic signed [7:0]        w_phase;
  logic [7:0]               w_amp;
  logic                     w_qual;
  logic                     w_step;
  logic                     w_win_done;
  logic signed [7:0]        w_diff;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_mean_full;
  logic [7:0]               w_peak_max;

  assign w_phase     = $signed(s_axis_dout_tdata[15:8]);
  assign w_amp       = s_axis_dout_tdata[7:0];
  assign w_qual      = s_axis_dout_tvalid && (w_amp >= AMP_THRESH);
  assign w_step      = (r_state == ST_ACC) && w_qual;
  assign w_win_done  = w_step && (r_cnt == CNT_LAST);
  assign w_diff      = wrap_diff(w_phase, r_prev_phase);
  assign w_acc_sum   = r_acc + $signed({{LOG2_N{w_diff[7]}}, w_diff});
  // The arithmetic shift rounds toward minus infinity, which gives the window mean.
  assign w_mean_full = w_acc_sum >>> LOG2_N;
  assign w_peak_max  = (w_amp > r_peak) ? w_amp : r_peak;

  // Register the FSM state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_SEEK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Choose the next state. clr drops the reference. So does any valid sample
  // whose amplitude is below threshold.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_SEEK;
    end else begin
      case (r_state)
        ST_SEEK: begin
          if (w_qual) begin
            w_state_nxt = ST_ACC;
          end else begin
            w_state_nxt = ST_SEEK;
          end
        end
        ST_ACC: begin
          if (s_axis_dout_tvalid && !w_qual) begin
            w_state_nxt = ST_SEEK;
          end else begin
            w_state_nxt = ST_ACC;
          end
        end
        default: w_state_nxt = ST_SEEK;
      endcase
    end
  end

  // Update the reference phase and the window accumulators.
  // The window survives a drop to SEEK. It is cleared only on completion, clr or reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev_phase <= 8'sd0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_peak       <= 8'd0;
    end else if (clr) begin
      r_prev_phase <= 8'sd0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_peak       <= 8'd0;
    end else if ((r_state == ST_SEEK) && w_qual) begin
      r_prev_phase <= w_phase;
    end else if (w_step) begin
      r_prev_phase <= w_phase;
      if (w_win_done) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_peak <= 8'd0;
      end else begin
        r_acc  <= w_acc_sum;
        r_cnt  <= r_cnt + CNT_ONE;
        r_peak <= w_peak_max;
      end
    end else begin
      r_prev_phase <= r_prev_phase;
    end
  end

  // Drive the result register, the ready/valid handshake and the sticky overrun flag.
  // A new result at the same edge as an accepted transfer replaces the old one
  // without flagging overrun.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= 16'd0;
      r_overrun <= 1'b0;
    end else if (clr) begin
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_win_done) begin
      r_tvalid <= 1'b1;
      r_tdata  <= {w_peak_max, w_mean_full[7:0]};
      if (r_tvalid && !m_axis_tready) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end else if (r_tvalid && m_axis_tready) begin
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= r_tvalid;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign overrun       = r_overrun;
  assign locked        = (r_state == ST_ACC);

endmodule

// File: doc/cordic_polar_freq_est.md
Name: cordic_polar_freq_est

Overview:
- Stage directly downstream of the cordic_0 translate (vector-to-polar) core.
- Consumes the core's {phase, amplitude} output stream and gates out samples whose amplitude is too low.
- Differences consecutive phases with ±pi wrap correction to get instantaneous frequency in rad/sample, then averages it over 2^LOG2_N samples.
- Emits {peak amplitude, mean frequency} per window on a ready/valid stream, for measurement and display logic.

Parameters:
- LOG2_N, 3: log2 of the number of phase differences per output window (N=8).
- AMP_THRESH, 8'd16: minimum amplitude for a sample to qualify, Q2.6 (16 = 0.25).
- PI_Q, 8'd101: pi in Q3.5 (3.156).
- TWO_PI_Q, 9'd201: 2·pi in Q3.5.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_dout_tvalid  in  1  polar sample valid, driven by the CORDIC core. There is no tready; every valid sample must be taken.
- s_axis_dout_tdata  in  16  [15:8] phase, signed Q3.5 radians; [7:0] amplitude, unsigned Q2.6.
- clr  in  1  synchronous restart: clears the window, reference and overrun.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  result accepted.
- m_axis_tdata  out  16  [15:8] peak amplitude (Q2.6); [7:0] mean frequency (signed Q3.5 rad/sample).
- locked  out  1  a reference phase is held (state ACC).
- overrun  out  1  sticky: an unaccepted result was overwritten.

Behaviour:
- Reset (aresetn low, asynchronous):
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, locked=0, overrun=0.
  - Internal: state=SEEK, accumulator=0, count=0, peak=0, prev_phase=0.
  - Reset mid-window discards all partial state.
- Qualifying sample: s_axis_dout_tvalid=1 and amp >= AMP_THRESH.
- FSM, state SEEK:
  - A qualifying sample stores prev_phase and moves to ACC. Nothing is accumulated.
  - Non-qualifying samples are ignored.
- FSM, state ACC:
  - On a qualifying sample, compute d = phase − prev_phase as a 9-bit signed value.
  - Wrap d: if d > PI_Q−1 then d −= TWO_PI_Q; if d < −(PI_Q−1) then d += TWO_PI_Q. The result lies in [−100,100] and is truncated to 8 bits.
  - acc += d (width 8+LOG2_N, signed); count++; peak = max(peak, amp); prev_phase = phase.
  - A non-qualifying valid sample returns to SEEK. acc, count and peak are kept; only the reference is dropped.
- Window completion:
  - When the Nth difference is accumulated at edge k, the output register loads {peak_incl_current, acc_incl_current >>> LOG2_N}.
  - The shift is arithmetic, truncating toward −inf.
  - m_axis_tvalid=1 after edge k (1-cycle latency).
  - At the same edge: acc=0, count=0, peak=0; state stays ACC with prev_phase updated.
- Output handshake:
  - m_axis_tdata holds stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid clears on a tvalid&tready edge unless a new result loads at that same edge. In that case tvalid stays 1, new data is presented, and overrun is not set.
- Overrun:
  - A new result loading while tvalid=1 and tready=0 overwrites the held result and sets overrun.
  - overrun clears only on clr or reset.
- clr:
  - Has priority over a sample in the same cycle; that sample is discarded.
  - Forces SEEK; clears acc, count, peak, m_axis_tvalid and overrun.
- locked = (state == ACC).
- Phases are assumed in [−101,101]; inputs outside this range are still wrapped by the same rule, with no error flag.

Test Plan:
- Constant phase: 9 samples phase=25 (pi/4), amp=64 -> one result tdata={8'd64, 8'd0}, one cycle after the 9th sample; locked=1 from after the 1st.
- Ramp: phases 0,10,…,80, amp=64 -> freq=10, peak=64. A peak of 90 on the 5th sample -> tdata[15:8]=90.
- Wrap: phases 70,80,90,100,−91,−81,−71,−61,−51 -> every d=10 (100→−91: −191+201), freq=10. Negative ramp 0,−10,…,−80 -> freq=−10 (8'hF6).
- Amplitude gating: phases 0,10,20, then amp=8 at phase 30, then 50,60,…:
  - The low sample drops locked for the cycle after it; 50 becomes the new reference with no 20→50 difference.
  - The result appears after 8 contributing differences with freq=10.
- Backpressure: hold tready=0 across two completed windows (freq 10 then 20) -> tdata freq=20, overrun=1. Raise tready -> tvalid drops next cycle. Pulse clr -> overrun=0.
- Reset/clr mid-window: assert aresetn=0 after 4 differences -> all outputs 0. After release, the first result needs 9 qualifying samples. clr coincident with a valid sample -> sample ignored, locked=0.
